clint_mh: RTL

Multi-hart core-local interruptor: holds a shared 64-bit `mtime`, plus one `msip` bit and one 64-bit `mtimecmp` per hart. It drives per-hart software and timer interrupt lines. It sits behind the standard AXI-to-peripheral bridge (`gpi_*` side). It replaces the dual-clock timer scheme: `mtime` lives entirely in the `clk` domain and advances on synchronised, prescaled edges of an asynchronous RTC input.

---
 rtl/clint_mh_pkg.sv | 21 ++
 rtl/clint_mh_tick.sv | 37 +++
 rtl/clint_mh.sv | 127 ++++++++++++
 3 files changed

// File: rtl/clint_mh_pkg.sv
// Shared constants and decode types for the multi-hart CLINT.
package clint_mh_pkg;

  localparam logic [15:0] MSIP_BASE     = 16'h0000;
  localparam logic [15:0] MTIMECMP_BASE = 16'h4000;
  localparam logic [15:0] MTIME_LO      = 16'hBFF8;
  localparam logic [15:0] MTIME_HI      = 16'hBFFC;

  localparam logic [63:0] MTIMECMP_RST  = '1;

  localparam int unsigned MAX_HARTS     = 16;
  localparam int unsigned HART_W        = $clog2(MAX_HARTS);

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_MSIP,
    SEL_MTIMECMP,
    SEL_MTIME
  } reg_sel_e;

endpackage

// File: rtl/clint_mh_tick.sv
// RTC synchroniser, rising-edge detector and prescaler producing a one-cycle mtime tick.
module clint_mh_tick #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned PRESCALE    = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic rtc_in,
  output logic tick
);

  localparam int unsigned CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic                   r_edge;
  logic [CW-1:0]          r_cnt;
  logic                   w_wrap;

  assign w_wrap = (r_cnt == CW'(PRESCALE - 1));
  assign tick   = r_edge & w_wrap;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync <= '0;
      r_prev <= 1'b0;
      r_edge <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], rtc_in};
      r_prev <= r_sync[SYNC_STAGES-1];
      r_edge <= r_sync[SYNC_STAGES-1] & ~r_prev;
      if (r_edge) r_cnt <= w_wrap ? '0 : r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/clint_mh.sv
// Multi-hart CLINT: mtime, per-hart msip/mtimecmp and interrupt lines behind the gpi bus.
// Optional CLINT_MH_SNAPSHOT_EN: mtime lo read latches hi into a shadow returned by hi reads.
module clint_mh
  import clint_mh_pkg::*;
#(
  parameter int unsigned NUM_HARTS   = 4,
  parameter int unsigned PRESCALE    = 1,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rtc_in,
  input  logic                 gpi_read,
  input  logic                 gpi_write,
  input  logic [15:0]          gpi_addr,
  input  logic [31:0]          gpi_wdata,
  output logic [31:0]          gpi_rdata,
  output logic [NUM_HARTS-1:0] intr_soft,
  output logic [NUM_HARTS-1:0] intr_timer
);

  logic [NUM_HARTS-1:0] r_msip;
  logic [63:0]          r_mtimecmp [NUM_HARTS];
  logic [63:0]          r_mtime;
  logic [31:0]          r_rdata;
  logic [NUM_HARTS-1:0] r_intr_timer;

  reg_sel_e             w_sel;
  logic [HART_W-1:0]    w_hart;
  logic                 w_hi;
  logic [31:0]          w_rdata;
  logic [31:0]          w_mtime_hi_rd;
  logic                 w_tick;
  logic                 w_unused;

  assign w_unused   = ^gpi_addr[1:0];
  assign gpi_rdata  = r_rdata;
  assign intr_soft  = r_msip;
  assign intr_timer = r_intr_timer;

  clint_mh_tick #(
    .SYNC_STAGES (SYNC_STAGES),
    .PRESCALE    (PRESCALE)
  ) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .rtc_in (rtc_in),
    .tick   (w_tick)
  );

  always_comb begin
    w_sel  = SEL_NONE;
    w_hart = '0;
    w_hi   = gpi_addr[2];
    if (gpi_addr[15:6] == MSIP_BASE[15:6]) begin
      w_sel  = SEL_MSIP;
      w_hart = gpi_addr[5:2];
    end else if (gpi_addr[15:7] == MTIMECMP_BASE[15:7]) begin
      w_sel  = SEL_MTIMECMP;
      w_hart = gpi_addr[6:3];
    end else if (gpi_addr[15:3] == MTIME_LO[15:3]) begin
      w_sel  = SEL_MTIME;
    end
  end

`ifdef CLINT_MH_SNAPSHOT_EN
  logic [31:0] r_shadow;

  always_ff @(posedge clk) begin
    if (!rst_n) r_shadow <= '0;
    else if (gpi_read && w_sel == SEL_MTIME && !w_hi) r_shadow <= r_mtime[63:32];
  end

  assign w_mtime_hi_rd = r_shadow;
`else
  assign w_mtime_hi_rd = r_mtime[63:32];
`endif

  // Hart indices at or above NUM_HARTS match no loop iteration, so they read 0.
  always_comb begin
    w_rdata = '0;
    case (w_sel)
      SEL_MSIP: begin
        for (int unsigned i = 0; i < NUM_HARTS; i++)
          if (w_hart == HART_W'(i)) w_rdata = {31'd0, r_msip[i]};
      end
      SEL_MTIMECMP: begin
        for (int unsigned i = 0; i < NUM_HARTS; i++)
          if (w_hart == HART_W'(i))
            w_rdata = w_hi ? r_mtimecmp[i][63:32] : r_mtimecmp[i][31:0];
      end
      SEL_MTIME: w_rdata = w_hi ? w_mtime_hi_rd : r_mtime[31:0];
      default:   w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_msip       <= '0;
      r_mtime      <= '0;
      r_rdata      <= '0;
      r_intr_timer <= '0;
      for (int unsigned i = 0; i < NUM_HARTS; i++) r_mtimecmp[i] <= MTIMECMP_RST;
    end else begin
      if (gpi_read) r_rdata <= w_rdata;

      // A half write in the tick cycle drops that tick entirely.
      if (gpi_write && w_sel == SEL_MTIME) begin
        if (w_hi) r_mtime[63:32] <= gpi_wdata;
        else      r_mtime[31:0]  <= gpi_wdata;
      end else if (w_tick) begin
        r_mtime <= r_mtime + 64'd1;
      end

      for (int unsigned i = 0; i < NUM_HARTS; i++) begin
        if (gpi_write && w_sel == SEL_MSIP && w_hart == HART_W'(i))
          r_msip[i] <= gpi_wdata[0];
        if (gpi_write && w_sel == SEL_MTIMECMP && w_hart == HART_W'(i)) begin
          if (w_hi) r_mtimecmp[i][63:32] <= gpi_wdata;
          else      r_mtimecmp[i][31:0]  <= gpi_wdata;
        end
        r_intr_timer[i] <= (r_mtime >= r_mtimecmp[i]);
      end
    end
  end

endmodule
